timed_cmd_dispatcher: RTL and testbench

Parametrised successor to the fixed-width command scheduler. It pops timestamped command records from the command FIFO and holds each one until its own free-running time counter reaches the record's timestamp. It then issues the record as a one-cycle write on a command bus, with one enable per target controller (pin controllers, ADC, DAC, crossbar). It sits between `command_fifo` and the controller array, and it owns the experiment timebase.

---
 rtl/timed_cmd_dispatcher.sv | 131 +++++++++++++
 tb/tb_timed_cmd_dispatcher.sv | 332 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/timed_cmd_dispatcher.sv
// Timed command dispatcher: pops timestamped records from the command FIFO, holds each
// until the free-running timebase reaches its timestamp, then pulses one target enable.
//
// state    | meaning
// S_IDLE   | waiting for a non-empty FIFO
// S_FETCH  | pop strobe to the FIFO
// S_WAIT   | waiting for the popped word to come back valid
// S_DECODE | dispatch on opcode, late check
// S_HOLD   | waiting for the timestamp to fall due
// S_ISSUE  | bus write pulse visible
module timed_cmd_dispatcher #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16,
  parameter int TIME_W      = 32,
  parameter int NUM_TARGETS = 16,
  localparam int TGT_W      = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1,
  localparam int REC_W      = 2 + TIME_W + ADDR_W + DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic [REC_W-1:0]       cmd_fifo_dout,
  input  logic                   cmd_fifo_empty,
  input  logic                   cmd_fifo_valid,
  output logic                   cmd_fifo_rd_en,
  output logic [ADDR_W-1:0]      cmd_bus_addr,
  output logic [DATA_W-1:0]      cmd_bus_data,
  output logic [NUM_TARGETS-1:0] cmd_bus_en,
  output logic                   cmd_bus_wr,
  output logic [TIME_W-1:0]      current_time,
  output logic [15:0]            late_count,
  output logic [15:0]            drop_count,
  output logic                   busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_WAIT, S_DECODE, S_HOLD, S_ISSUE
  } state_t;

  localparam logic [1:0] OP_WRITE      = 2'd0;
  localparam logic [1:0] OP_RESET_TIME = 2'd1;

  state_t                   state, state_nxt;
  logic [REC_W-1:0]         rec;
  logic [1:0]               rec_op;
  logic [TIME_W-1:0]        rec_ts;
  logic [ADDR_W-1:0]        rec_addr;
  logic [DATA_W-1:0]        rec_data;
  logic [TGT_W-1:0]         tgt;
  logic [TIME_W-1:0]        diff;
  logic                     due, overdue, tgt_ok;
  logic [NUM_TARGETS-1:0]   tgt_onehot;

  assign rec_op   = rec[REC_W-1 -: 2];
  assign rec_ts   = rec[TIME_W+ADDR_W+DATA_W-1 -: TIME_W];
  assign rec_addr = rec[ADDR_W+DATA_W-1 -: ADDR_W];
  assign rec_data = rec[DATA_W-1:0];
  assign tgt      = rec_addr[ADDR_W-1 -: TGT_W];

  // Modular difference keeps the due test correct across timebase wrap.
  assign diff    = current_time - rec_ts;
  assign due     = ~diff[TIME_W-1];
  assign overdue = due && (diff != '0);
  assign tgt_ok  = int'(tgt) < NUM_TARGETS;

  always_comb begin
    tgt_onehot = '0;
    for (int i = 0; i < NUM_TARGETS; i++) begin
      if (int'(tgt) == i) tgt_onehot[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt      = state;
    cmd_fifo_rd_en = 1'b0;
    busy           = (state != S_IDLE);
    case (state)
      S_IDLE:   if (!cmd_fifo_empty) state_nxt = S_FETCH;
      S_FETCH: begin
        cmd_fifo_rd_en = 1'b1;
        state_nxt      = S_WAIT;
      end
      S_WAIT:   if (cmd_fifo_valid) state_nxt = S_DECODE;
      S_DECODE: state_nxt = (rec_op == OP_WRITE) ? S_HOLD : S_IDLE;
      S_HOLD:   if (due) state_nxt = S_ISSUE;
      S_ISSUE:  state_nxt = S_IDLE;
      default:  state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      rec          <= '0;
      current_time <= '0;
      late_count   <= '0;
      drop_count   <= '0;
      cmd_bus_addr <= '0;
      cmd_bus_data <= '0;
      cmd_bus_en   <= '0;
      cmd_bus_wr   <= 1'b0;
    end else begin
      if (state == S_DECODE && rec_op == OP_RESET_TIME) current_time <= '0;
      else if (run)                                     current_time <= current_time + TIME_W'(1);

      if (state == S_WAIT && cmd_fifo_valid) rec <= cmd_fifo_dout;

      if (state == S_DECODE && rec_op == OP_WRITE && overdue && late_count != 16'hFFFF)
        late_count <= late_count + 16'd1;

      // Bus outputs are loaded on the HOLD->ISSUE edge so the pulse occupies the ISSUE cycle.
      cmd_bus_en <= '0;
      cmd_bus_wr <= 1'b0;
      if (state == S_HOLD && due) begin
        cmd_bus_addr <= rec_addr;
        cmd_bus_data <= rec_data;
        if (tgt_ok) begin
          cmd_bus_en <= tgt_onehot;
          cmd_bus_wr <= 1'b1;
        end else if (drop_count != 16'hFFFF) begin
          drop_count <= drop_count + 16'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_timed_cmd_dispatcher.sv
// Bench for timed_cmd_dispatcher: FIFO responder, schedule-level reference model and
// per-cycle monitor, with directed scenarios followed by randomized batches.
module tb_timed_cmd_dispatcher;
  localparam int TW = 8;
  localparam int NT = 12;
  localparam int RW = 2 + TW + 16 + 16;

  logic          clk = 1'b0;
  logic          rst, run;
  logic [RW-1:0] cmd_fifo_dout;
  logic          cmd_fifo_empty, cmd_fifo_valid, cmd_fifo_rd_en;
  logic [15:0]   cmd_bus_addr, cmd_bus_data;
  logic [NT-1:0] cmd_bus_en;
  logic          cmd_bus_wr;
  logic [TW-1:0] current_time;
  logic [15:0]   late_count, drop_count;
  logic          busy;

  timed_cmd_dispatcher #(.DATA_W(16), .ADDR_W(16), .TIME_W(TW), .NUM_TARGETS(NT)) dut (
    .clk(clk), .rst(rst), .run(run),
    .cmd_fifo_dout(cmd_fifo_dout), .cmd_fifo_empty(cmd_fifo_empty),
    .cmd_fifo_valid(cmd_fifo_valid), .cmd_fifo_rd_en(cmd_fifo_rd_en),
    .cmd_bus_addr(cmd_bus_addr), .cmd_bus_data(cmd_bus_data),
    .cmd_bus_en(cmd_bus_en), .cmd_bus_wr(cmd_bus_wr),
    .current_time(current_time), .late_count(late_count),
    .drop_count(drop_count), .busy(busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]  op;
    logic [7:0]  ts;
    logic [15:0] addr;
    logic [15:0] data;
    int          stall;
  } rec_t;

  typedef struct {
    int          cyc;
    logic [15:0] addr;
    logic [15:0] data;
    logic [NT-1:0] en;
  } iss_t;

  rec_t  fifo_q[$];
  rec_t  batch[$];
  iss_t  exp_issue[$];
  int    exp_rd[$];
  int    exp_treset[$];
  int    base_c = 0;
  logic [7:0] base_v = 8'd0;
  int    exp_late = 0, exp_drop = 0;
  bit    chk_on = 1'b0;
  int    checks = 0, failures = 0;
  logic [15:0] last_addr = 16'd0, last_data = 16'd0;
  int    pulses = 0;
  logic [7:0] pulse_time = 8'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] req);
    checks++;
    assert (obs === req) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, req);
    end
  endtask

  function automatic logic [7:0] tnow(input int c);
    return 8'(base_v + (c - base_c));
  endfunction

  // FIFO responder: one popped word per rd_en, presented after rd_en plus the record's stall.
  initial begin
    rec_t r;
    cmd_fifo_valid = 1'b0;
    cmd_fifo_dout  = '0;
    cmd_fifo_empty = 1'b1;
    forever begin
      @(negedge clk);
      cmd_fifo_empty = (fifo_q.size() == 0);
      if (rst === 1'b1 && cmd_fifo_rd_en === 1'b1) begin
        chk("rd_en_when_empty", 32'(fifo_q.size() > 0), 32'd1);
        if (fifo_q.size() > 0) begin
          r = fifo_q.pop_front();
          cmd_fifo_empty = (fifo_q.size() == 0);
          @(posedge clk);
          repeat (r.stall) @(posedge clk);
          #1;
          cmd_fifo_valid = 1'b1;
          cmd_fifo_dout  = {r.op, r.ts, r.addr, r.data};
          @(posedge clk);
          #1;
          cmd_fifo_valid = 1'b0;
        end
      end
    end
  end

  // Cycle monitor: timebase, pop strobes and bus activity against the planned schedule.
  initial begin
    iss_t e;
    logic [NT-1:0] en_req;
    logic rd_req;
    forever begin
      @(negedge clk);
      if (chk_on) begin
        if (exp_treset.size() > 0 && exp_treset[0] == cyc) begin
          base_c = cyc;
          base_v = 8'd0;
          void'(exp_treset.pop_front());
        end
        chk("current_time", 32'(current_time), 32'(tnow(cyc)));
        rd_req = 1'b0;
        if (exp_rd.size() > 0 && exp_rd[0] == cyc) begin
          rd_req = 1'b1;
          void'(exp_rd.pop_front());
        end
        chk("rd_en", 32'(cmd_fifo_rd_en), 32'(rd_req));
        en_req = '0;
        if (exp_issue.size() > 0 && exp_issue[0].cyc == cyc) begin
          e = exp_issue.pop_front();
          en_req    = e.en;
          last_addr = e.addr;
          last_data = e.data;
        end
        chk("bus_en", 32'(cmd_bus_en), 32'(en_req));
        chk("bus_wr", 32'(cmd_bus_wr), 32'(|en_req));
        chk("bus_addr", 32'(cmd_bus_addr), 32'(last_addr));
        chk("bus_data", 32'(cmd_bus_data), 32'(last_data));
        if (cmd_bus_wr === 1'b1) begin
          pulses++;
          pulse_time = current_time;
        end
      end
    end
  end

  task automatic add(input logic [1:0] op, input logic [7:0] ts, input logic [15:0] addr,
                     input logic [15:0] data, input int stall);
    rec_t r;
    r.op = op; r.ts = ts; r.addr = addr; r.data = data; r.stall = stall;
    batch.push_back(r);
  endtask

  // Schedule model: FIFO seen non-empty in IDLE at cycle c -> pop at c+1, decode at c+3+stall,
  // a WRITE is held until the timebase reaches its stamp and pulses the cycle after.
  task automatic plan_and_push(input int p);
    int c, dec, hold, wt, bc;
    logic [7:0] bv, td, th, d, w8;
    logic [3:0] tg;
    iss_t e;
    c = p; bc = base_c; bv = base_v;
    foreach (batch[i]) begin
      exp_rd.push_back(c + 1);
      dec = c + 3 + batch[i].stall;
      if (batch[i].op == 2'd0) begin
        td = 8'(bv + (dec - bc));
        d  = td - batch[i].ts;
        if (!d[7] && d != 8'd0) exp_late++;
        hold = dec + 1;
        th = 8'(bv + (hold - bc));
        d  = th - batch[i].ts;
        w8 = batch[i].ts - th;
        wt = d[7] ? {24'd0, w8} : 0;
        e.cyc  = hold + wt + 1;
        e.addr = batch[i].addr;
        e.data = batch[i].data;
        tg = batch[i].addr[15:12];
        e.en = (int'(tg) < NT) ? (NT'(1) << tg) : '0;
        if (e.en == '0) exp_drop++;
        exp_issue.push_back(e);
        c = e.cyc + 1;
      end else begin
        if (batch[i].op == 2'd1) begin
          exp_treset.push_back(dec + 1);
          bc = dec + 1;
          bv = 8'd0;
        end
        c = dec + 1;
      end
      fifo_q.push_back(batch[i]);
    end
    batch.delete();
  endtask

  task automatic wait_done();
    int n = 0;
    bit done = 1'b0;
    while (!done && n < 3000) begin
      @(posedge clk);
      #1;
      n++;
      done = exp_issue.size() == 0 && exp_rd.size() == 0 && exp_treset.size() == 0 &&
             fifo_q.size() == 0 && !cmd_fifo_valid && busy === 1'b0;
    end
    chk("batch_done", 32'(done), 32'd1);
    chk("late_count", 32'(late_count), 32'(exp_late));
    chk("drop_count", 32'(drop_count), 32'(exp_drop));
  endtask

  task automatic run_batch();
    plan_and_push(cyc);
    wait_done();
  endtask

  task automatic wait_time(input logic [7:0] v);
    int n = 0;
    while (tnow(cyc) != v && n < 300) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_en"},   32'(cmd_bus_en), 32'd0);
    chk({tag, "_wr"},   32'(cmd_bus_wr), 32'd0);
    chk({tag, "_addr"}, 32'(cmd_bus_addr), 32'd0);
    chk({tag, "_data"}, 32'(cmd_bus_data), 32'd0);
    chk({tag, "_time"}, 32'(current_time), 32'd0);
    chk({tag, "_late"}, 32'(late_count), 32'd0);
    chk({tag, "_drop"}, 32'(drop_count), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_rden"}, 32'(cmd_fifo_rd_en), 32'd0);
  endtask

  initial begin
    int p0, n, r;
    rst = 1'b0;
    run = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    base_c = cyc;
    base_v = 8'd0;
    chk_on = 1'b1;
    chk_all_zero("reset");
    rst = 1'b1;
    run = 1'b1;
    @(posedge clk);
    #1;

    // Timed write to target 3, due at time 100
    p0 = pulses;
    add(2'd0, 8'd100, 16'h3005, 16'hBEEF, 0);
    run_batch();
    chk("tw_pulses", 32'(pulses - p0), 32'd1);
    chk("tw_issue_time", 32'(pulse_time), 32'd101);
    chk("tw_en_addr", 32'(cmd_bus_addr), 32'h3005);

    // Two overdue records, issued in FIFO order
    wait_time(8'd50);
    p0 = pulses;
    add(2'd0, 8'd5, 16'h1111, 16'hA001, 0);
    add(2'd0, 8'd3, 16'h2222, 16'hA002, 0);
    run_batch();
    chk("late_pulses", 32'(pulses - p0), 32'd2);
    chk("late_two", 32'(late_count), 32'd2);

    // Reset while a record is parked in HOLD
    add(2'd0, tnow(cyc) + 8'd100, 16'h1234, 16'h5678, 0);
    plan_and_push(cyc);
    repeat (6) @(posedge clk);
    #1;
    chk("hold_busy", 32'(busy), 32'd1);
    rst = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    base_c = cyc;
    base_v = 8'd0;
    exp_issue.delete();
    exp_rd.delete();
    exp_treset.delete();
    exp_late = 0;
    exp_drop = 0;
    last_addr = 16'd0;
    last_data = 16'd0;
    chk_all_zero("midhold_reset");
    p0 = pulses;
    repeat (150) @(posedge clk);
    #1;
    chk("no_reissue", 32'(pulses - p0), 32'd0);
    chk("post_reset_idle", 32'(busy), 32'd0);

    // Target 13 is out of range and dropped; the following record still issues
    p0 = pulses;
    add(2'd0, tnow(cyc) + 8'd2, 16'hD000, 16'h1111, 0);
    add(2'd0, tnow(cyc) + 8'd4, 16'h5ABC, 16'h2222, 0);
    run_batch();
    chk("bad_drop", 32'(drop_count), 32'd1);
    chk("bad_pulses", 32'(pulses - p0), 32'd1);

    // FIFO slow to return data
    add(2'd0, tnow(cyc) + 8'd10, 16'h0042, 16'h3333, 20);
    plan_and_push(cyc);
    repeat (12) @(posedge clk);
    #1;
    chk("bp_busy", 32'(busy), 32'd1);
    chk("bp_rden", 32'(cmd_fifo_rd_en), 32'd0);
    wait_done();

    // Timestamp beyond the wrap, then a timebase reset
    wait_time(8'd250);
    p0 = pulses;
    add(2'd0, 8'd4, 16'h2777, 16'h4444, 0);
    run_batch();
    chk("wrap_pulses", 32'(pulses - p0), 32'd1);
    chk("wrap_issue_time", 32'(pulse_time), 32'd5);
    add(2'd1, 8'h99, 16'h0000, 16'h0000, 0);
    add(2'd2, 8'h10, 16'h1000, 16'h0000, 0);
    run_batch();

    // Randomized batches
    for (int b = 0; b < 8; b++) begin
      n = $urandom_range(1, 6);
      for (int k = 0; k < n; k++) begin
        r = $urandom_range(0, 9);
        add((r < 7) ? 2'd0 : (r < 8) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3,
            8'(tnow(cyc) + 8'($urandom_range(0, 60)) - 8'd20),
            16'($urandom), 16'($urandom), $urandom_range(0, 3));
      end
      run_batch();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
